// File: rtl/bp_common_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_common_pkg
//  Description : Shared BlackParrot memory-engine parameters (flit counts
//                for the data command and data response channels).
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_common_pkg;

    // Number of flits that make up one data response message
    localparam int bp_data_resp_num_flit_gp = 4;

    // Number of flits that make up one data command message
    localparam int bp_data_cmd_num_flit_gp  = 4;

endpackage : bp_common_pkg
`default_nettype wire

// File: rtl/bp_me_flit_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : bp_me_flit_deserializer
//  Description : Reassembles num_flit_p flits into one wide message. A collect
//                buffer gathers flits while a separate output register holds
//                the previous message, so streams run at one flit per cycle.
//                Framing errors (early or missing last) raise a sticky flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_me_flit_deserializer
    import bp_common_pkg::*;
#(
    parameter int flit_width_p = 128,
    parameter int num_flit_p   = bp_data_resp_num_flit_gp
)
(
    input  logic                               clk_i,
    input  logic                               reset_n_i,

    input  logic                               flit_v_i,
    input  logic [flit_width_p-1:0]            flit_i,
    input  logic                               flit_last_i,
    output logic                               flit_ready_o,

    output logic                               data_v_o,
    output logic [num_flit_p*flit_width_p-1:0] data_o,
    input  logic                               data_yumi_i,

    output logic                               err_o,
    input  logic                               err_clr_i
);

    localparam int                 CNT_W    = (num_flit_p > 1) ? $clog2(num_flit_p) : 1;
    localparam int                 MSG_W    = num_flit_p * flit_width_p;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(num_flit_p - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_v_q, data_v_d;
    logic             err_q, err_d;
    logic [MSG_W-1:0] collect_q, collect_d;
    logic [MSG_W-1:0] data_q, data_d;

    logic w_at_last;
    logic w_ready;
    logic w_accept;
    logic w_complete;
    logic w_frame_err;

    // The final slot can only be filled when the output register is free or
    // being drained this cycle; ready is held low throughout reset.
    assign w_at_last   = (cnt_q == LAST_CNT);
    assign w_ready     = reset_n_i & (~w_at_last | ~data_v_q | data_yumi_i);
    assign w_accept    = flit_v_i & w_ready;
    assign w_complete  = w_accept & w_at_last & flit_last_i;
    assign w_frame_err = w_accept & (w_at_last ^ flit_last_i);

    assign flit_ready_o = w_ready;
    assign data_v_o     = data_v_q;
    assign data_o       = data_q;
    assign err_o        = err_q;

    // Write the accepted flit into its slot; the completed message is taken
    // from collect_d so the final flit reaches the output on the same edge.
    always_comb begin
        collect_d = collect_q;
        for (int k = 0; k < num_flit_p; k++) begin
            if (w_accept && (cnt_q == CNT_W'(k))) begin
                collect_d[k*flit_width_p +: flit_width_p] = flit_i;
            end
        end
    end

    // Next-state for counter, valid, error flag and output payload.
    always_comb begin
        cnt_d    = cnt_q;
        data_v_d = data_v_q;
        err_d    = err_q;
        data_d   = data_q;

        if (w_accept) begin
            // Any last flag or the final slot ends the frame, good or bad
            if (w_at_last || flit_last_i) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (w_complete) begin
            data_v_d = 1'b1;
            data_d   = collect_d;
        end else if (data_yumi_i) begin
            data_v_d = 1'b0;
        end

        // A new error wins over a simultaneous clear
        if (w_frame_err) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    // Control state with asynchronous reset; partial messages are dropped.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q    <= '0;
            data_v_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            data_v_q <= data_v_d;
            err_q    <= err_d;
        end
    end

    // Payload registers carry no reset; validity is tracked by the control state.
    always_ff @(posedge clk_i) begin
        collect_q <= collect_d;
        data_q    <= data_d;
    end

endmodule : bp_me_flit_deserializer
`default_nettype wire

// File: tb/tb_bp_me_flit_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_me_flit_deserializer
//  Description : Self-checking bench for the flit deserializer (4 x 16-bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_me_flit_deserializer;

    localparam int FW = 16;
    localparam int NF = 4;
    localparam int MW = FW * NF;

    logic          clk_i       = 1'b0;
    logic          reset_n_i   = 1'b0;
    logic          flit_v_i    = 1'b0;
    logic [FW-1:0] flit_i      = '0;
    logic          flit_last_i = 1'b0;
    logic          data_yumi_i = 1'b0;
    logic          err_clr_i   = 1'b0;
    logic          flit_ready_o;
    logic          data_v_o;
    logic [MW-1:0] data_o;
    logic          err_o;

    bp_me_flit_deserializer #(
        .flit_width_p (FW),
        .num_flit_p   (NF)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .flit_v_i     (flit_v_i),
        .flit_i       (flit_i),
        .flit_last_i  (flit_last_i),
        .flit_ready_o (flit_ready_o),
        .data_v_o     (data_v_o),
        .data_o       (data_o),
        .data_yumi_i  (data_yumi_i),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int            checks = 0;
    int            passes = 0;
    logic [MW-1:0] exp_q[$];
    int            m_cnt = 0;
    bit            m_vld = 0;
    bit            m_err = 0;
    logic [FW-1:0] m_buf[NF];
    bit            auto_yumi  = 0;
    bit            force_yumi = 0;

    // One clock cycle: drive yumi, compare outputs against the model at the
    // negative edge, advance the model, then return 1 unit after posedge.
    task automatic tick(output bit acc);
        bit            yumi;
        bit            exp_rdy;
        bit            at_last;
        bit            done;
        bit            seterr;
        logic [MW-1:0] msg;
        @(negedge clk_i);
        yumi        = m_vld && (auto_yumi || force_yumi);
        data_yumi_i = yumi;
        #1;
        exp_rdy = (m_cnt != NF - 1) || !m_vld || yumi;
        checks++;
        if (data_v_o !== m_vld) $display("FAIL data_v: got %b want %b t=%0t", data_v_o, m_vld, $time);
        else passes++;
        checks++;
        if (flit_ready_o !== exp_rdy) $display("FAIL ready: got %b want %b t=%0t", flit_ready_o, exp_rdy, $time);
        else passes++;
        checks++;
        if (err_o !== m_err) $display("FAIL err: got %b want %b t=%0t", err_o, m_err, $time);
        else passes++;
        if (m_vld) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL scoreboard: got data %h want none t=%0t", data_o, $time);
            else if (data_o !== exp_q[0]) $display("FAIL data: got %h want %h t=%0t", data_o, exp_q[0], $time);
            else passes++;
        end
        if (yumi && exp_q.size() > 0) void'(exp_q.pop_front());
        acc    = flit_v_i && exp_rdy;
        done   = 0;
        seterr = 0;
        if (acc) begin
            at_last       = (m_cnt == NF - 1);
            m_buf[m_cnt]  = flit_i;
            if (at_last && flit_last_i) begin
                msg = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                exp_q.push_back(msg);
                done = 1;
            end
            if (flit_last_i != at_last) seterr = 1;
            m_cnt = (at_last || flit_last_i) ? 0 : m_cnt + 1;
        end
        if (done) m_vld = 1;
        else if (yumi) m_vld = 0;
        if (seterr) m_err = 1;
        else if (err_clr_i) m_err = 0;
        @(posedge clk_i);
        #1;
        data_yumi_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) tick(acc);
    endtask

    task automatic send_flit(input logic [FW-1:0] d, input bit last);
        bit acc;
        acc         = 0;
        flit_v_i    = 1'b1;
        flit_i      = d;
        flit_last_i = last;
        for (int i = 0; i < 20; i++) begin
            tick(acc);
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            $display("FAIL send_timeout: flit %h not accepted within 20 cycles", d);
        end
        flit_v_i    = 1'b0;
        flit_last_i = 1'b0;
    endtask

    task automatic send_msg(input logic [FW-1:0] base);
        for (int i = 0; i < NF; i++) send_flit(base + FW'(i), i == NF - 1);
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_vld = 0;
        m_err = 0;
        exp_q.delete();
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        checks++;
        if (flit_ready_o !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", flit_ready_o);
        else passes++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({flit_ready_o, data_v_o, err_o} !== 3'b000)
            $display("FAIL reset_state: got rdy/v/err %b want 000", {flit_ready_o, data_v_o, err_o});
        else passes++;
        model_clear();
        repeat (2) @(posedge clk_i);
        release_reset();
        idle(2);
    endtask

    task automatic test_single();
        auto_yumi = 0;
        send_msg(16'h000A);
        checks++;
        if (data_v_o !== 1'b1 || data_o !== 64'h000D_000C_000B_000A)
            $display("FAIL single_msg: got v=%b %h want v=1 000d000c000b000a", data_v_o, data_o);
        else passes++;
        idle(2);
        force_yumi = 1;
        idle(1);
        force_yumi = 0;
        idle(1);
    endtask

    task automatic test_back_to_back();
        time t0;
        auto_yumi = 1;
        t0 = $time;
        for (int i = 0; i < 8; i++) send_flit(16'h0100 + FW'(i), (i % 4) == 3);
        checks++;
        if ($time - t0 != 80) $display("FAIL b2b_rate: got %0t time units want 80", $time - t0);
        else passes++;
        idle(3);
        checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_backpressure();
        bit acc;
        auto_yumi = 0;
        send_msg(16'h0200);
        for (int i = 0; i < 3; i++) send_flit(16'h0230 + FW'(i), 1'b0);
        flit_v_i    = 1'b1;
        flit_i      = 16'h0233;
        flit_last_i = 1'b1;
        repeat (2) begin
            tick(acc);
            checks++;
            if (flit_ready_o !== 1'b0) $display("FAIL bp_stall: got ready %b want 0", flit_ready_o);
            else passes++;
        end
        force_yumi = 1;
        tick(acc);
        force_yumi  = 0;
        flit_v_i    = 1'b0;
        flit_last_i = 1'b0;
        checks++;
        if (data_v_o !== 1'b1 || data_o !== 64'h0233_0232_0231_0230)
            $display("FAIL bp_switch: got v=%b %h want v=1 0233023202310230", data_v_o, data_o);
        else passes++;
        force_yumi = 1;
        idle(1);
        force_yumi = 0;
        idle(1);
    endtask

    task automatic test_early_last();
        auto_yumi = 1;
        send_flit(16'h0300, 1'b0);
        send_flit(16'h0301, 1'b1);
        idle(1);
        checks++;
        if (err_o !== 1'b1 || data_v_o !== 1'b0)
            $display("FAIL early_last: got err=%b v=%b want err=1 v=0", err_o, data_v_o);
        else passes++;
        send_msg(16'h0310);
        idle(2);
        checks++;
        if (exp_q.size() != 0) $display("FAIL early_recover: got %0d pending want 0", exp_q.size());
        else passes++;
        err_clr_i = 1'b1;
        idle(1);
        err_clr_i = 1'b0;
    endtask

    task automatic test_missing_last();
        auto_yumi = 1;
        for (int i = 0; i < NF; i++) send_flit(16'h0400 + FW'(i), 1'b0);
        idle(1);
        checks++;
        if (err_o !== 1'b1 || data_v_o !== 1'b0)
            $display("FAIL missing_last: got err=%b v=%b want err=1 v=0", err_o, data_v_o);
        else passes++;
        err_clr_i = 1'b1;
        send_flit(16'h0411, 1'b1);
        checks++;
        if (err_o !== 1'b1) $display("FAIL err_clr_vs_new: got %b want 1", err_o);
        else passes++;
        idle(1);
        err_clr_i = 1'b0;
        checks++;
        if (err_o !== 1'b0) $display("FAIL err_clear: got %b want 0", err_o);
        else passes++;
    endtask

    task automatic test_reset_mid();
        auto_yumi = 0;
        send_msg(16'h04F0);
        send_flit(16'h0500, 1'b0);
        send_flit(16'h0501, 1'b0);
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (flit_ready_o !== 1'b0 || data_v_o !== 1'b0)
            $display("FAIL reset_mid: got rdy=%b v=%b want 0 0", flit_ready_o, data_v_o);
        else passes++;
        model_clear();
        @(posedge clk_i);
        release_reset();
        auto_yumi = 1;
        send_msg(16'h0510);
        idle(3);
        checks++;
        if (exp_q.size() != 0) $display("FAIL reset_recover: got %0d pending want 0", exp_q.size());
        else passes++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_bp_me_flit_deserializer
`default_nettype wire
